// File: rtl/sudoku_pkg.sv
// Shared constants, types and cube indexing for the sudoku grid loader.
package sudoku_pkg;

    localparam int N      = 9;
    localparam int CELLS  = N * N;
    localparam int CUBE_W = N * N * N;

    typedef logic [CUBE_W-1:0] cube_t;
    typedef logic [3:0]        digit_t;

    typedef enum logic {
        LOAD,
        FULL
    } state_t;

    function automatic logic [9:0] cube_idx(
        input logic [3:0] row,
        input logic [3:0] col,
        input digit_t     digit
    );
        return 10'(32'(row) * CELLS + 32'(col) * N + 32'(digit) - 1);
    endfunction

endpackage

// File: rtl/sudoku_digit_decode.sv
// Cell digit to 9-bit candidate slice; SUDOKU_EMPTY_ALL_CANDIDATES_EN
// makes empty/illegal cells decode to all candidates instead of none.
module sudoku_digit_decode
    import sudoku_pkg::*;
(
    input  digit_t         digit,
    output logic [N-1:0]   onehot,
    output logic           illegal
);

`ifdef SUDOKU_EMPTY_ALL_CANDIDATES_EN
    localparam logic [N-1:0] EMPTY = '1;
`else
    localparam logic [N-1:0] EMPTY = '0;
`endif

    always_comb begin
        illegal = 1'b0;
        onehot  = EMPTY;
        unique case (1'b1)
            (digit == 4'd0): onehot = EMPTY;
            (digit > 4'd9): begin
                illegal = 1'b1;
                onehot  = EMPTY;
            end
            default: onehot = N'(1) << (digit - 4'd1);
        endcase
    end

endmodule

// File: rtl/sudoku_grid_loader.sv
// Collects 81 raster-ordered cell digits into the one-hot candidate cube
// and hands the finished cube downstream with a sticky error flag.
module sudoku_grid_loader
    import sudoku_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cell_valid,
    output logic        cell_ready,
    input  logic [3:0]  cell_digit,
    input  logic        cell_last,
    input  logic        load_abort,
    output logic        grid_valid,
    input  logic        grid_ready,
    output cube_t       grid_cube,
    output logic        grid_err
);

    state_t       state;
    logic [3:0]   row;
    logic [3:0]   col;
    logic [N-1:0] dec;
    logic         illegal;
    logic         at_last;
    logic [9:0]   base;

    sudoku_digit_decode u_dec (
        .digit   (cell_digit),
        .onehot  (dec),
        .illegal (illegal)
    );

    assign at_last = (row == 4'd8) && (col == 4'd8);
    assign base    = cube_idx(row, col, 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD;
            row        <= '0;
            col        <= '0;
            grid_cube  <= '0;
            grid_err   <= 1'b0;
            grid_valid <= 1'b0;
            cell_ready <= 1'b1;
        end else begin
            unique case (state)
                LOAD: begin
                    if (load_abort) begin
                        row      <= '0;
                        col      <= '0;
                        grid_err <= 1'b0;
                    end else if (cell_valid) begin
                        grid_cube[base +: N] <= dec;
                        // framing error: last flag must coincide with cell 80
                        grid_err <= grid_err | illegal | (cell_last ^ at_last);
                        if (at_last) begin
                            row        <= '0;
                            col        <= '0;
                            state      <= FULL;
                            cell_ready <= 1'b0;
                            grid_valid <= 1'b1;
                        end else if (col == 4'd8) begin
                            col <= '0;
                            row <= row + 4'd1;
                        end else begin
                            col <= col + 4'd1;
                        end
                    end
                end
                FULL: begin
                    if (grid_ready) begin
                        state      <= LOAD;
                        grid_err   <= 1'b0;
                        grid_valid <= 1'b0;
                        cell_ready <= 1'b1;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
